interp_ctrl: RTL



---
 rtl/interp_ctrl_pkg.sv | 33 +++
 rtl/interp_ctrl_if.sv | 33 +++
 rtl/interp_nco.sv | 52 +++++
 rtl/interp_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/interp_ctrl_pkg.sv
// Shared fixed-point definitions for the symbol-sync interpolator path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package interp_ctrl_pkg;

   localparam int SYM_WIDTH = 1;
   localparam int INT_WIDTH = 1;
   localparam int DEC_WIDTH = 14;
   localparam int WORD_W    = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
   localparam int EXT_W     = WORD_W + 1;

   typedef logic signed [WORD_W-1:0] word_t;
   typedef logic signed [EXT_W-1:0]  ext_t;

   localparam word_t ONE    = word_t'(2**DEC_WIDTH);
   localparam word_t ONE_M1 = word_t'(2**DEC_WIDTH - 1);
   localparam word_t HALF   = word_t'(2**(DEC_WIDTH-1));
   localparam word_t LSB    = word_t'(1);

   // Saturate a one-bit-wider intermediate into [lo, hi], otherwise truncate to a word.
   function automatic word_t sat_word(input ext_t x, input word_t lo, input word_t hi);
      word_t r;
      if (x < ext_t'(lo)) begin
         r = lo;
      end else if (x > ext_t'(hi)) begin
         r = hi;
      end else begin
         r = word_t'(x);
      end
      return r;
   endfunction

endpackage

// File: rtl/interp_ctrl_if.sv
// Sample/step input bundle and strobe/tap output bundle of interp_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; the sample source is never stalled.
interface interp_ctrl_if;
   import interp_ctrl_pkg::*;

   logic  in_valid;
   word_t in_i;
   word_t in_q;
   word_t w_in;
   logic  w_load;

   logic  out_valid;
   word_t uk;
   word_t buf_i1, buf_i2, buf_i3, buf_i4;
   word_t buf_q1, buf_q2, buf_q3, buf_q4;
   logic  sym_phase;

   // Sample source / loop filter side.
   modport master (
      output in_valid, in_i, in_q, w_in, w_load,
      input  out_valid, uk, buf_i1, buf_i2, buf_i3, buf_i4,
             buf_q1, buf_q2, buf_q3, buf_q4, sym_phase
   );

   // Interpolator controller side.
   modport slave (
      input  in_valid, in_i, in_q, w_in, w_load,
      output out_valid, uk, buf_i1, buf_i2, buf_i3, buf_i4,
             buf_q1, buf_q2, buf_q3, buf_q4, sym_phase
   );

endinterface

// File: rtl/interp_nco.sv
// Modulo-1 decrementing NCO with clamped step register; flags underflow and derives uk.
// Latency: underflow_o/uk_o are combinational from current state; eta/W update on the edge.
// Backpressure: none; advances only when step_i is high.
module interp_nco
   import interp_ctrl_pkg::*;
#(
   parameter word_t W_RESET   = HALF,
   parameter word_t ETA_RESET = HALF
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  step_i,
   input  word_t w_in_i,
   input  logic  w_load_i,
   output logic  underflow_o,
   output word_t uk_o
);

   word_t eta_q, eta_d;
   word_t w_q, w_d;
   ext_t  diff;

   // Next-state of eta and W; the step used this cycle is always the registered W,
   // so a load coinciding with a sample only affects the following samples.
   always_comb begin
      diff        = ext_t'(eta_q) - ext_t'(w_q);
      underflow_o = step_i & diff[EXT_W-1];
      // 2*eta is exact only at W = 0.5; it is the accepted approximation of mu.
      uk_o        = sat_word(ext_t'(eta_q) <<< 1, '0, ONE_M1);
      eta_d       = eta_q;
      if (step_i) begin
         eta_d = diff[EXT_W-1] ? word_t'(diff + ext_t'(ONE)) : word_t'(diff);
      end
      w_d = w_q;
      if (w_load_i) begin
         // A zero or negative step would stall the loop; >= ONE would skip samples.
         w_d = sat_word(ext_t'(w_in_i), LSB, ONE_M1);
      end
   end

   // NCO state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         eta_q <= ETA_RESET;
         w_q   <= W_RESET;
      end else begin
         eta_q <= eta_d;
         w_q   <= w_d;
      end
   end

endmodule

// File: rtl/interp_ctrl.sv
// Interpolator controller: I/Q delay line plus NCO; emits uk and 4 aligned taps per underflow.
// Latency: 1 cycle from the accepting edge to out_valid; taps/uk hold between strobes.
// Backpressure: none; one sample per cycle when in_valid, downstream must take each strobe.
module interp_ctrl
   import interp_ctrl_pkg::*;
#(
   parameter word_t W_RESET   = HALF,
   parameter word_t ETA_RESET = HALF
) (
   input  logic         clk,
   input  logic         rst_n,
   interp_ctrl_if.slave bus
);

   logic  uf;
   word_t uk_nco;
   logic  strobe;

   // Three history samples suffice: the oldest output tap is the third history
   // entry at the moment of the strobe, together with the incoming sample.
   word_t dly_i_q [0:2];
   word_t dly_q_q [0:2];
   word_t dly_i_d [0:2];
   word_t dly_q_d [0:2];
   logic [2:0] fill_q, fill_d;

   logic  out_valid_q, out_valid_d;
   word_t uk_q, uk_d;
   word_t tap_i_q [0:3];
   word_t tap_q_q [0:3];
   word_t tap_i_d [0:3];
   word_t tap_q_d [0:3];
   logic  phase_q, phase_d;

   interp_nco #(
      .W_RESET   (W_RESET),
      .ETA_RESET (ETA_RESET)
   ) u_nco (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_i      (bus.in_valid),
      .w_in_i      (bus.w_in),
      .w_load_i    (bus.w_load),
      .underflow_o (uf),
      .uk_o        (uk_nco)
   );

   // Shift the delay line per sample and latch uk/taps only on a strobe after warm-up.
   always_comb begin
      strobe      = uf & (fill_q >= 3'd3);
      dly_i_d     = dly_i_q;
      dly_q_d     = dly_q_q;
      fill_d      = fill_q;
      out_valid_d = strobe;
      uk_d        = uk_q;
      tap_i_d     = tap_i_q;
      tap_q_d     = tap_q_q;
      phase_d     = phase_q;
      if (bus.in_valid) begin
         dly_i_d[0] = bus.in_i;
         dly_i_d[1] = dly_i_q[0];
         dly_i_d[2] = dly_i_q[1];
         dly_q_d[0] = bus.in_q;
         dly_q_d[1] = dly_q_q[0];
         dly_q_d[2] = dly_q_q[1];
         if (fill_q != 3'd4) begin
            fill_d = fill_q + 3'd1;
         end
      end
      if (strobe) begin
         uk_d       = uk_nco;
         tap_i_d[0] = bus.in_i;
         tap_i_d[1] = dly_i_q[0];
         tap_i_d[2] = dly_i_q[1];
         tap_i_d[3] = dly_i_q[2];
         tap_q_d[0] = bus.in_q;
         tap_q_d[1] = dly_q_q[0];
         tap_q_d[2] = dly_q_q[1];
         tap_q_d[3] = dly_q_q[2];
         phase_d    = ~phase_q;
      end
   end

   // Delay line, fill count and registered outputs; phase resets to 1 so the first strobe reads 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            dly_i_q[k] <= '0;
            dly_q_q[k] <= '0;
         end
         for (int k = 0; k < 4; k++) begin
            tap_i_q[k] <= '0;
            tap_q_q[k] <= '0;
         end
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         uk_q        <= '0;
         phase_q     <= 1'b1;
      end else begin
         dly_i_q     <= dly_i_d;
         dly_q_q     <= dly_q_d;
         tap_i_q     <= tap_i_d;
         tap_q_q     <= tap_q_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         uk_q        <= uk_d;
         phase_q     <= phase_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.uk        = uk_q;
   assign bus.buf_i1    = tap_i_q[0];
   assign bus.buf_i2    = tap_i_q[1];
   assign bus.buf_i3    = tap_i_q[2];
   assign bus.buf_i4    = tap_i_q[3];
   assign bus.buf_q1    = tap_q_q[0];
   assign bus.buf_q2    = tap_q_q[1];
   assign bus.buf_q3    = tap_q_q[2];
   assign bus.buf_q4    = tap_q_q[3];
   assign bus.sym_phase = phase_q;

endmodule
